// File: rtl/align_pkg.sv
// Shared types for the alignment transmitter: FSM encoding, 8-bit word type, idle word default.
package align_pkg;

    typedef logic [7:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRAIN     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_DATA      = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam word_t IDLE_WORD_DEFAULT = 8'h00;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/align_pattern_tx.sv
// Link-training transmitter: sends a training pattern until the remote receiver locks, then user data.
// Optional timeout/retry logic is enabled by defining ALIGN_TX_TIMEOUT_EN.
module align_pattern_tx
    import align_pkg::*;
#(
    parameter word_t       TRAIN_WORD      = 8'h55,
    parameter word_t       IDLE_WORD       = IDLE_WORD_DEFAULT,
    parameter int unsigned MIN_TRAIN_WORDS = 64,
    parameter int unsigned LOCK_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 4096,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic       txclkdiv,
    input  logic       rst,
    input  logic       start_train,
    input  logic       aligned_in,
    input  logic [7:0] user_data,
    input  logic       user_valid,
    output logic       user_ready,
    output logic [7:0] txdata,
    output logic       train_active,
    output logic       train_done,
    output logic       train_fail,
    output logic [2:0] state
);

    localparam int unsigned WCNT_W = $clog2(MIN_TRAIN_WORDS + 1);
    localparam int unsigned LCNT_W = $clog2(LOCK_CYCLES + 1);

    logic              aligned_s;
    state_t            state_q, state_d;
    logic [WCNT_W-1:0] word_cnt, word_cnt_d, word_inc;
    logic [LCNT_W-1:0] lock_cnt, lock_cnt_d, lock_inc;
    word_t             txdata_d;
    logic              user_ready_d, train_active_d, train_done_d;

`ifdef ALIGN_TX_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RCNT_W = $clog2(MAX_RETRY + 1);

    logic [TCNT_W-1:0] to_cnt, to_cnt_d, to_inc;
    logic [RCNT_W-1:0] retry_cnt, retry_cnt_d, retry_inc;
    logic              train_fail_q, train_fail_d;

    assign to_inc    = (to_cnt == TCNT_W'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + TCNT_W'(1);
    assign retry_inc = (retry_cnt == RCNT_W'(MAX_RETRY)) ? retry_cnt : retry_cnt + RCNT_W'(1);
    assign train_fail = train_fail_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(MAX_RETRY)};
    assign train_fail = 1'b0;
`endif

    sync_2ff u_sync (
        .clk (txclkdiv),
        .rst (rst),
        .d   (aligned_in),
        .q   (aligned_s)
    );

    // Saturating increments; counters never wrap.
    assign word_inc = (word_cnt == WCNT_W'(MIN_TRAIN_WORDS)) ? word_cnt : word_cnt + WCNT_W'(1);
    assign lock_inc = (lock_cnt == LCNT_W'(LOCK_CYCLES)) ? lock_cnt : lock_cnt + LCNT_W'(1);

    assign state = state_q;

    always_ff @(posedge txclkdiv or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_cnt     <= '0;
            lock_cnt     <= '0;
            txdata       <= IDLE_WORD;
            user_ready   <= 1'b0;
            train_active <= 1'b0;
            train_done   <= 1'b0;
`ifdef ALIGN_TX_TIMEOUT_EN
            to_cnt       <= '0;
            retry_cnt    <= '0;
            train_fail_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            word_cnt     <= word_cnt_d;
            lock_cnt     <= lock_cnt_d;
            txdata       <= txdata_d;
            user_ready   <= user_ready_d;
            train_active <= train_active_d;
            train_done   <= train_done_d;
`ifdef ALIGN_TX_TIMEOUT_EN
            to_cnt       <= to_cnt_d;
            retry_cnt    <= retry_cnt_d;
            train_fail_q <= train_fail_d;
`endif
        end
    end

    // Next state; registered outputs are derived from the next state so they line up with state.
    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt;
        lock_cnt_d     = lock_cnt;
        train_done_d   = train_done;
        txdata_d       = IDLE_WORD;
        user_ready_d   = 1'b0;
        train_active_d = 1'b0;
`ifdef ALIGN_TX_TIMEOUT_EN
        to_cnt_d       = to_cnt;
        retry_cnt_d    = retry_cnt;
        train_fail_d   = train_fail_q;
`endif

        if (start_train) begin
            state_d      = ST_TRAIN;
            word_cnt_d   = '0;
            lock_cnt_d   = '0;
            train_done_d = 1'b0;
`ifdef ALIGN_TX_TIMEOUT_EN
            to_cnt_d     = '0;
            retry_cnt_d  = '0;
            train_fail_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_TRAIN: begin
                    word_cnt_d = word_inc;
                    if (word_inc == WCNT_W'(MIN_TRAIN_WORDS)) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    lock_cnt_d = aligned_s ? lock_inc : '0;
                    if (aligned_s && (lock_inc == LCNT_W'(LOCK_CYCLES))) begin
                        state_d      = ST_DATA;
                        train_done_d = 1'b1;
                    end
`ifdef ALIGN_TX_TIMEOUT_EN
                    else begin
                        to_cnt_d = to_inc;
                        if (to_inc == TCNT_W'(TIMEOUT_CYCLES)) begin
                            retry_cnt_d = retry_inc;
                            to_cnt_d    = '0;
                            word_cnt_d  = '0;
                            lock_cnt_d  = '0;
                            if (retry_inc < RCNT_W'(MAX_RETRY)) begin
                                state_d = ST_TRAIN;
                            end else begin
                                state_d      = ST_FAIL;
                                train_fail_d = 1'b1;
                            end
                        end
                    end
`endif
                end
                ST_DATA: ;
                ST_FAIL: ;
                default: state_d = ST_IDLE;
            endcase
        end

        train_active_d = (state_d == ST_TRAIN) || (state_d == ST_WAIT_LOCK);
        user_ready_d   = (state_d == ST_DATA);
        if (train_active_d) begin
            txdata_d = TRAIN_WORD;
        end else if ((state_d == ST_DATA) && (state_q == ST_DATA) && user_valid && user_ready) begin
            txdata_d = user_data;
        end
    end

endmodule

// File: tb/tb_align_pattern_tx.sv
// Self-checking bench for align_pattern_tx: directed scenarios plus random traffic against a rule-level model.
module tb_align_pattern_tx;

    localparam int MIN   = 64;
    localparam int LOCK  = 8;
    localparam int TMO   = 4096;
    localparam int RETRY = 3;

    logic       txclkdiv;
    logic       rst;
    logic       start_train;
    logic       aligned_in;
    logic [7:0] user_data;
    logic       user_valid;
    logic       user_ready;
    logic [7:0] txdata;
    logic       train_active;
    logic       train_done;
    logic       train_fail;
    logic [2:0] state;

    int vectors = 0;
    int errors  = 0;
    int n;

    // Reference model state (spec encoding: 0 idle, 1 train, 2 wait-lock, 3 data, 4 fail).
    int         ms, m_words, m_lock, m_to, m_retry;
    bit         m_done, m_fail, m_ready, m_active, m_s1, m_s2;
    logic [7:0] m_tx;

    align_pattern_tx dut (
        .txclkdiv     (txclkdiv),
        .rst          (rst),
        .start_train  (start_train),
        .aligned_in   (aligned_in),
        .user_data    (user_data),
        .user_valid   (user_valid),
        .user_ready   (user_ready),
        .txdata       (txdata),
        .train_active (train_active),
        .train_done   (train_done),
        .train_fail   (train_fail),
        .state        (state)
    );

    initial txclkdiv = 1'b0;
    always #5 txclkdiv = ~txclkdiv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = 0; m_words = 0; m_lock = 0; m_to = 0; m_retry = 0;
        m_done = 0; m_fail = 0; m_ready = 0; m_active = 0; m_s1 = 0; m_s2 = 0;
        m_tx = 8'h00;
    endtask

    task automatic model_step();
        int ns;
        ns = ms;
        if (start_train) begin
            ns = 1; m_words = 0; m_lock = 0; m_to = 0; m_retry = 0; m_done = 0; m_fail = 0;
        end else begin
            case (ms)
                1: begin
                    m_words++;
                    if (m_words >= MIN) ns = 2;
                end
                2: begin
                    m_lock = m_s2 ? m_lock + 1 : 0;
                    if (m_lock >= LOCK) begin
                        ns = 3; m_done = 1;
                    end
`ifdef ALIGN_TX_TIMEOUT_EN
                    else begin
                        m_to++;
                        if (m_to >= TMO) begin
                            m_retry++; m_to = 0; m_words = 0; m_lock = 0;
                            if (m_retry < RETRY) ns = 1;
                            else begin
                                ns = 4; m_fail = 1;
                            end
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
        m_active = (ns == 1) || (ns == 2);
        m_ready  = (ns == 3);
        if (m_active) m_tx = 8'h55;
        else if (ns == 3 && ms == 3 && user_valid) m_tx = user_data;
        else m_tx = 8'h00;
        m_s2 = m_s1;
        m_s1 = aligned_in;
        ms   = ns;
    endtask

    // One clock: model advances on the edge, DUT outputs compared on the falling edge.
    task automatic tick();
        @(posedge txclkdiv);
        if (rst) model_reset();
        else model_step();
        @(negedge txclkdiv);
        chk("state", 32'(state), 32'(ms));
        chk("txdata", 32'(txdata), 32'(m_tx));
        chk("user_ready", 32'(user_ready), 32'(m_ready));
        chk("train_active", 32'(train_active), 32'(m_active));
        chk("train_done", 32'(train_done), 32'(m_done));
        chk("train_fail", 32'(train_fail), 32'(m_fail));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_txdata"}, 32'(txdata), 32'h00);
        chk({tag, "_ready"}, 32'(user_ready), 32'd0);
        chk({tag, "_active"}, 32'(train_active), 32'd0);
        chk({tag, "_done"}, 32'(train_done), 32'd0);
        chk({tag, "_fail"}, 32'(train_fail), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_train = 1'b0; aligned_in = 1'b0; user_data = 8'h00; user_valid = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("por");
        repeat (3) tick();
        rst = 1'b0;

        // No training starts without a request.
        repeat (5) tick();
        chk("idle_wait", 32'(state), 32'd0);

        // Training length, then a non-locking aligned pattern, then a clean lock.
        start_train = 1'b1;
        tick();
        start_train = 1'b0;
        n = 0;
        while (state == 3'd1 && n < 200) begin
            n++;
            tick();
        end
        chk("train_len", 32'(n), 32'd64);
        chk("enter_wait", 32'(state), 32'd2);
        repeat (4) begin
            aligned_in = 1'b1;
            repeat (5) tick();
            aligned_in = 1'b0;
            tick();
        end
        chk("no_lock", 32'(state), 32'd2);
        aligned_in = 1'b1;
        n = 0;
        while (state != 3'd3 && n < 50) begin
            tick();
            n++;
        end
        chk("lock_latency", 32'(n), 32'd10);
        chk("lock_done", 32'(train_done), 32'd1);

        // Directed payload words, each one cycle after input.
        user_valid = 1'b1; user_data = 8'hA5;
        tick();
        chk("data_a5", 32'(txdata), 32'hA5);
        user_data = 8'h3C;
        tick();
        chk("data_3c", 32'(txdata), 32'h3C);
        user_valid = 1'b0;
        tick();
        chk("data_idle", 32'(txdata), 32'h00);

        // Random payload; aligned_in wanders and must be ignored.
        repeat (200) begin
            user_valid = 1'($urandom_range(0, 1));
            user_data  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) aligned_in = ~aligned_in;
            tick();
        end
        chk("data_hold", 32'(state), 32'd3);

        // Asynchronous reset in the middle of a clock period.
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        tick();
        rst = 1'b0;
        user_valid = 1'b0;
        repeat (5) tick();
        chk("post_rst_idle", 32'(state), 32'd0);

        // Restart coincides with the final lock cycle: restart wins.
        aligned_in = 1'b1;
        start_train = 1'b1;
        tick();
        start_train = 1'b0;
        n = 0;
        while (state != 3'd2 && n < 200) begin
            tick();
            n++;
        end
        chk("race_wait", 32'(state), 32'd2);
        repeat (LOCK - 1) tick();
        start_train = 1'b1;
        tick();
        start_train = 1'b0;
        chk("race_state", 32'(state), 32'd1);
        chk("race_done", 32'(train_done), 32'd0);

        // Random restarts, aligned bursts and payload.
        repeat (1500) begin
            start_train = ($urandom_range(0, 199) == 0);
            user_valid  = 1'($urandom_range(0, 1));
            user_data   = 8'($urandom);
            if ($urandom_range(0, 11) == 0) aligned_in = ~aligned_in;
            tick();
        end
        start_train = 1'b0;

`ifdef ALIGN_TX_TIMEOUT_EN
        // Three full attempts with no lock end in FAIL.
        aligned_in = 1'b0;
        start_train = 1'b1;
        tick();
        start_train = 1'b0;
        n = 0;
        while (state != 3'd4 && n < 13000) begin
            tick();
            n++;
        end
        chk("fail_len", 32'(n), 32'd12480);
        chk("fail_flag", 32'(train_fail), 32'd1);
        chk("fail_txdata", 32'(txdata), 32'h00);
        user_valid = 1'b1;
        repeat (5) tick();
        chk("fail_hold", 32'(state), 32'd4);
        chk("fail_ready", 32'(user_ready), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
